gru_cell: RTL and testbench

GRU_CELL -- requirements
Module: gru_cell

---
 rtl/gru_cell_pkg.sv | 23 ++
 rtl/gru_cell_multiplier.sv | 66 ++++++
 rtl/gru_cell.sv | 135 +++++++++++++
 tb/tb_gru_cell.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gru_cell_pkg.sv
// gru_cell_pkg: shared Q-format constants, saturation helpers and GRU cell state encoding
package gru_cell_pkg;
    localparam int FRAC_BITS = 16;
    localparam logic signed [31:0] ONE     = 32'sh0001_0000;
    localparam logic signed [31:0] HALF    = 32'sh0000_8000;
    localparam logic signed [31:0] MAX_POS = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MAX_NEG = 32'sh8000_0000;
    typedef logic signed [127:0] wide_t;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC_R = 3'd1;
    localparam logic [2:0] S_MAC_Z = 3'd2;
    localparam logic [2:0] S_MAC_H = 3'd3;
    localparam logic [2:0] S_BLEND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction
    function automatic wide_t sat(input wide_t v, input int w);
        wide_t mx;
        mx = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        return clamp(v, -mx - wide_t'(1), mx);
    endfunction
endpackage

// File: rtl/gru_cell_multiplier.sv
// multiplier: registered fixed-point multiply with start/done handshake and saturation
module multiplier #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         done,
    input  logic signed [DATA_WIDTH-1:0] w,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] mult_result
);
    import gru_cell_pkg::*;
    localparam int DW = DATA_WIDTH;
    localparam logic [1:0] M_IDLE = 2'd0, M_MUL = 2'd1, M_RES = 2'd2, M_DONE = 2'd3;
    logic [1:0] st_q, st_d;
    logic signed [DW-1:0] w_q, w_d, x_q, x_d, res_q, res_d;
    logic signed [2*DW-1:0] prod_q, prod_d;
    logic done_q, done_d;
    always_comb begin
        st_d   = st_q;
        w_d    = w_q;
        x_d    = x_q;
        prod_d = prod_q;
        res_d  = res_q;
        done_d = done_q;
        if (st_q == M_IDLE && start) begin
            w_d  = w;
            x_d  = x;
            st_d = M_MUL;
        end
        if (st_q == M_MUL) begin
            prod_d = $signed({{DW{w_q[DW-1]}}, w_q}) * $signed({{DW{x_q[DW-1]}}, x_q});
            st_d   = M_RES;
        end
        if (st_q == M_RES) begin
            res_d  = DW'(sat(wide_t'(prod_q >>> FRAC_BITS), DW));
            done_d = 1'b1;
            st_d   = M_DONE;
        end
        if (st_q == M_DONE && !start) begin
            done_d = 1'b0;
            st_d   = M_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= M_IDLE;
            w_q    <= '0;
            x_q    <= '0;
            prod_q <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            w_q    <= w_d;
            x_q    <= x_d;
            prod_q <= prod_d;
            res_q  <= res_d;
            done_q <= done_d;
        end
    end
    assign done        = done_q;
    assign mult_result = res_q;
endmodule

// File: rtl/gru_cell.sv
// gru_cell: one GRU hidden unit computed serially on a single shared multiplier
module gru_cell #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = 16,
    parameter int GRU_UNITS      = 3,
    parameter int INPUT_FEATURES = 3,
    parameter int CELL_INDEX     = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_start_cell,
    output logic                                   o_done_cell,
    input  logic                                   i_computation_phase,
    input  logic [INPUT_FEATURES*DATA_WIDTH-1:0]   i_input_vector_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]        i_prev_hidden_state_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]        i_r_modified_hidden_flat,
    input  logic [INPUT_FEATURES*DATA_WIDTH-1:0]   i_Wr_flat,
    input  logic [INPUT_FEATURES*DATA_WIDTH-1:0]   i_Wz_flat,
    input  logic [INPUT_FEATURES*DATA_WIDTH-1:0]   i_Wh_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]        i_Ur_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]        i_Uz_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]        i_Uh_flat,
    input  logic signed [DATA_WIDTH-1:0]           i_br,
    input  logic signed [DATA_WIDTH-1:0]           i_bz,
    input  logic signed [DATA_WIDTH-1:0]           i_bh,
    output logic signed [DATA_WIDTH-1:0]           o_new_hidden_state
);
    import gru_cell_pkg::*;
    localparam int DW = DATA_WIDTH;
    localparam int AW = DW + 8;
    localparam int N  = INPUT_FEATURES + GRU_UNITS;
    localparam int IW = $clog2(N + 1);
    localparam wide_t ONE_W  = wide_t'(1) <<< FRAC_BITS;
    localparam wide_t HALF_W = ONE_W >>> 1;
    logic [2:0] state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic signed [AW-1:0] acc_q, acc_d, acc_sum;
    logic signed [DW-1:0] z_q, z_d, hc_q, hc_d, out_q, out_d;
    logic done_q, done_d, armed_q, armed_d;
    logic mult_start, mult_done, mac, last;
    logic signed [DW-1:0] mult_w, mult_x, mult_result, bias, h_cell, sig_v, tnh_v, blend_v;
    logic [INPUT_FEATURES*DW-1:0] w_row;
    logic [GRU_UNITS*DW-1:0] u_row, h_vec;
    wide_t dot;
    assign h_cell     = i_prev_hidden_state_flat[CELL_INDEX*DW +: DW];
    assign mac        = state_q inside {S_MAC_R, S_MAC_Z, S_MAC_H, S_BLEND};
    // start drops while done is seen so each product costs exactly four cycles
    assign mult_start = mac && !mult_done;
    always_comb begin
        w_row  = (state_q == S_MAC_R) ? i_Wr_flat : (state_q == S_MAC_Z) ? i_Wz_flat : i_Wh_flat;
        u_row  = (state_q == S_MAC_R) ? i_Ur_flat : (state_q == S_MAC_Z) ? i_Uz_flat : i_Uh_flat;
        h_vec  = (state_q == S_MAC_H) ? i_r_modified_hidden_flat : i_prev_hidden_state_flat;
        bias   = (state_q == S_MAC_R) ? i_br : (state_q == S_MAC_Z) ? i_bz : i_bh;
        mult_w = '0;
        mult_x = '0;
        for (int k = 0; k < INPUT_FEATURES; k++)
            if (idx_q == IW'(k)) begin
                mult_w = w_row[k*DW +: DW];
                mult_x = i_input_vector_flat[k*DW +: DW];
            end
        for (int j = 0; j < GRU_UNITS; j++)
            if (idx_q == IW'(INPUT_FEATURES + j)) begin
                mult_w = u_row[j*DW +: DW];
                mult_x = h_vec[j*DW +: DW];
            end
        if (state_q == S_BLEND) begin
            mult_w = (idx_q == '0) ? DW'(ONE_W - wide_t'(z_q)) : z_q;
            mult_x = (idx_q == '0) ? hc_q : h_cell;
        end
    end
    always_comb begin
        acc_sum = acc_q + AW'(mult_result);
        dot     = sat(wide_t'(acc_sum) + wide_t'(bias), DW);
        sig_v   = DW'(clamp((dot >>> 2) + HALF_W, wide_t'(0), ONE_W));
        tnh_v   = DW'(clamp(dot, -ONE_W, ONE_W));
        blend_v = DW'(sat(wide_t'(acc_sum), DW));
        last    = idx_q == ((state_q == S_BLEND) ? IW'(1) : IW'(N - 1));
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        z_d     = z_q;
        hc_d    = hc_q;
        out_d   = out_q;
        done_d  = done_q;
        armed_d = armed_q | !i_start_cell;
        if (state_q == S_IDLE && i_start_cell && armed_q) begin
            state_d = i_computation_phase ? S_MAC_Z : S_MAC_R;
            idx_d   = '0;
            acc_d   = '0;
            armed_d = 1'b0;
        end
        if (mac && mult_done) begin
            acc_d = last ? '0 : acc_sum;
            idx_d = last ? '0 : idx_q + IW'(1);
            if (last) begin
                state_d = (state_q == S_MAC_Z) ? S_MAC_H : (state_q == S_MAC_H) ? S_BLEND : S_DONE;
                z_d     = (state_q == S_MAC_Z) ? sig_v : z_q;
                hc_d    = (state_q == S_MAC_H) ? tnh_v : hc_q;
                out_d   = (state_q == S_MAC_R) ? sig_v : (state_q == S_BLEND) ? blend_v : out_q;
                done_d  = state_q == S_MAC_R || state_q == S_BLEND;
            end
        end
        if (state_q == S_DONE && !i_start_cell) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            z_q     <= '0;
            hc_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            hc_q    <= hc_d;
            out_q   <= out_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end
    multiplier #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC_BITS)) u_mult (
        .clk(clk), .rst(rst), .start(mult_start), .done(mult_done),
        .w(mult_w), .x(mult_x), .mult_result(mult_result)
    );
    assign o_done_cell        = done_q;
    assign o_new_hidden_state = out_q;
endmodule

// File: tb/tb_gru_cell.sv
// tb_gru_cell: directed checks of the GRU cell and its multiplier against hand-computed Q16.16 values
module tb_gru_cell;
    import gru_cell_pkg::*;
    localparam int DW = 32, NF = 3, NU = 3;
    localparam int P0_MAX = 4 * (NF + NU) + 8, P1_MAX = 8 * (NF + NU) + 16;
    logic clk = 1'b0, rst, start, phase, done;
    logic [NF*DW-1:0] x_flat, wr, wz, wh;
    logic [NU*DW-1:0] h_flat, rh_flat, ur, uz, uh;
    logic [DW-1:0] br, bz, bh, out;
    logic m_start, m_done;
    logic [DW-1:0] m_w, m_x, m_res;
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    gru_cell #(.DATA_WIDTH(DW), .FRAC_BITS(16), .GRU_UNITS(NU), .INPUT_FEATURES(NF), .CELL_INDEX(0)) dut (
        .clk(clk), .rst(rst), .i_start_cell(start), .o_done_cell(done), .i_computation_phase(phase),
        .i_input_vector_flat(x_flat), .i_prev_hidden_state_flat(h_flat), .i_r_modified_hidden_flat(rh_flat),
        .i_Wr_flat(wr), .i_Wz_flat(wz), .i_Wh_flat(wh), .i_Ur_flat(ur), .i_Uz_flat(uz), .i_Uh_flat(uh),
        .i_br(br), .i_bz(bz), .i_bh(bh), .o_new_hidden_state(out)
    );
    multiplier #(.DATA_WIDTH(DW), .FRAC_BITS(16)) mul (
        .clk(clk), .rst(rst), .start(m_start), .done(m_done), .w(m_w), .x(m_x), .mult_result(m_res)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic clear_all();
        {x_flat, wr, wz, wh} = '0;
        {h_flat, rh_flat, ur, uz, uh} = '0;
        {br, bz, bh} = '0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic run_op(input logic ph, input string tag, input logic [DW-1:0] exp, input int bound);
        int n;
        @(negedge clk);
        phase = ph;
        start = 1'b1;
        wait_done(n);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_out"}, out, exp);
        check({tag, "_lat"}, n <= bound, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, done, 1'b0);
    endtask
    task automatic mult_op(input string tag, input logic [DW-1:0] w, input logic [DW-1:0] x, input logic [DW-1:0] exp);
        int n = 0;
        @(negedge clk);
        m_w = w;
        m_x = x;
        m_start = 1'b1;
        while (!m_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_res"}, m_res, exp);
        @(negedge clk);
        check({tag, "_hold"}, m_done, 1'b1);
        m_start = 1'b0;
        @(negedge clk);
        check({tag, "_clr"}, m_done, 1'b0);
    endtask
    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        phase = 1'b0;
        m_start = 1'b0;
        m_w = '0;
        m_x = '0;
        clear_all();
        repeat (3) @(negedge clk);
        check("rst_done", done, 1'b0);
        check("rst_out", out, 32'h0);
        check("rst_mdone", m_done, 1'b0);
        rst = 1'b0;
        mult_op("mul_basic", 32'h0002_0000, 32'h0001_8000, 32'h0003_0000);
        mult_op("mul_satp", 32'h7FFF_0000, 32'h0002_0000, MAX_POS);
        mult_op("mul_satn", 32'h8000_0000, 32'h0002_0000, MAX_NEG);
        mult_op("mul_neg", 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000);
        run_op(1'b0, "p0_zero", HALF, P0_MAX);
        wr[0 +: DW] = ONE;
        x_flat[0 +: DW] = 32'h0002_0000;
        run_op(1'b0, "p0_one", ONE, P0_MAX);
        x_flat[0 +: DW] = 32'h0004_0000;
        run_op(1'b0, "p0_clamp_hi", ONE, P0_MAX);
        x_flat[0 +: DW] = 32'hFFFC_0000;
        run_op(1'b0, "p0_clamp_lo", 32'h0, P0_MAX);
        clear_all();
        wr[DW +: DW] = HALF;
        x_flat[DW +: DW] = ONE;
        ur[0 +: DW] = ONE;
        h_flat[0 +: DW] = 32'hFFFF_0000;
        br = ONE;
        run_op(1'b0, "p0_mix", 32'h0000_A000, P0_MAX);
        clear_all();
        bh = HALF;
        h_flat[0 +: DW] = ONE;
        run_op(1'b1, "p1_half", 32'h0000_C000, P1_MAX);
        bh = 32'h0003_0000;
        run_op(1'b1, "p1_hclamp", ONE, P1_MAX);
        bz = 32'hFFFE_0000;
        bh = 32'hFFFD_0000;
        run_op(1'b1, "p1_zzero", 32'hFFFF_0000, P1_MAX);
        clear_all();
        h_flat[0 +: DW] = ONE;
        h_flat[DW +: DW] = HALF;
        uh[DW +: DW] = ONE;
        rh_flat[DW +: DW] = 32'h0000_4000;
        run_op(1'b1, "p1_rh", 32'h0000_A000, P1_MAX);
        clear_all();
        @(negedge clk);
        phase = 1'b0;
        start = 1'b1;
        wait_done(n);
        check("rt_out", out, HALF);
        repeat (2) @(negedge clk);
        check("rt_held", done, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("rt_drop", done, 1'b0);
        repeat (40) @(negedge clk);
        check("rt_single", done, 1'b0);
        check("rt_out_hold", out, HALF);
        bh = HALF;
        h_flat[0 +: DW] = ONE;
        @(negedge clk);
        phase = 1'b1;
        start = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_out", out, 32'h0);
        rst = 1'b0;
        clear_all();
        run_op(1'b0, "post_rst", HALF, P0_MAX);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
